cdc_tx_arbiter: RTL and testbench



---
 rtl/cdc_tx_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cdc_tx_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_tx_arbiter.sv
// ----------------------------------------------------------------------------
// cdc_tx_arbiter
//
// Round-robin arbiter and launch sequencer for the source side of a 4-phase
// CDC handshake channel. Several clients share one channel. The winner's
// payload is captured together with its client index and launched through
// the channel's ready/busy interface. The word is held stable until the
// handshake completes, and completion is then reported to the winning client.
//
// Ports
//   i_clk          source-domain clock (also clocks the channel source side)
//   i_rst_n        asynchronous active-low reset
//   i_req          per-client request level, held until granted
//   i_data         flattened payloads, client k at [k*G_WIDTH +: G_WIDTH]
//   o_gnt          one-cycle pulse: the client's payload has been captured
//   o_done         one-cycle pulse: the granted transfer has completed
//   o_cdc_ready    one-cycle launch strobe to the channel
//   o_cdc_data     {client_id, payload} to the channel, registered
//   i_cdc_busy     channel busy flag
//   o_err_timeout  sticky watchdog flag, cleared only by reset
// ----------------------------------------------------------------------------
module cdc_tx_arbiter #(
    parameter int G_REQUESTERS = 4,
    parameter int G_WIDTH      = 4,
    parameter int G_TIMEOUT    = 1023,
    localparam int G_ID_W      = ($clog2(G_REQUESTERS) > 1) ? $clog2(G_REQUESTERS) : 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [G_REQUESTERS-1:0]           i_req,
    input  logic [G_REQUESTERS*G_WIDTH-1:0]   i_data,
    output logic [G_REQUESTERS-1:0]           o_gnt,
    output logic [G_REQUESTERS-1:0]           o_done,
    output logic                              o_cdc_ready,
    output logic [G_WIDTH+G_ID_W-1:0]         o_cdc_data,
    input  logic                              i_cdc_busy,
    output logic                              o_err_timeout
);

    localparam int WD_W = $clog2(G_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_LAUNCH      = 2'd1;
    localparam logic [1:0] ST_WAIT_ACCEPT = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE   = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic [G_ID_W-1:0]           last_q, last_d;
    logic [WD_W-1:0]             wd_q, wd_d;
    logic [G_REQUESTERS-1:0]     gnt_q, gnt_d;
    logic [G_REQUESTERS-1:0]     done_q, done_d;
    logic                        ready_q, ready_d;
    logic [G_WIDTH+G_ID_W-1:0]   data_q, data_d;
    logic                        err_q, err_d;

    // Unflattened view of the client payloads.
    logic [G_WIDTH-1:0] payload [G_REQUESTERS];

    genvar gi;
    generate
        for (gi = 0; gi < G_REQUESTERS; gi++) begin : g_payload
            assign payload[gi] = i_data[gi*G_WIDTH +: G_WIDTH];
        end
    endgenerate

    // Round-robin search: walk upward from the client after the last winner,
    // wrapping at G_REQUESTERS, and take the first active request.
    logic              found;
    logic [G_ID_W-1:0] win_idx;
    logic [G_ID_W-1:0] cand;

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = last_q;
        for (int off = 0; off < G_REQUESTERS; off++) begin
            if (cand == G_ID_W'(G_REQUESTERS - 1)) begin
                cand = '0;
            end else begin
                cand = cand + G_ID_W'(1);
            end
            if (!found && i_req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wd_d    = wd_q;
        gnt_d   = '0;
        done_d  = '0;
        ready_d = ready_q;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                // A busy channel (including the busy it reports out of
                // reset) blocks any new grant.
                if (!i_cdc_busy && found) begin
                    gnt_d[win_idx] = 1'b1;
                    ready_d        = 1'b1;
                    data_d         = {win_idx, payload[win_idx]};
                    last_d         = win_idx;
                    wd_d           = '0;
                    state_d        = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                ready_d = 1'b0;
                state_d = ST_WAIT_ACCEPT;
            end
            ST_WAIT_ACCEPT: begin
                if (wd_q != WD_W'(G_TIMEOUT)) begin
                    wd_d = wd_q + WD_W'(1);
                end
                if (i_cdc_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (wd_q != WD_W'(G_TIMEOUT)) begin
                    wd_d = wd_q + WD_W'(1);
                end
                // data_q is untouched here: the destination samples it
                // asynchronously until busy falls.
                if (!i_cdc_busy) begin
                    done_d[last_q] = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The watchdog only flags; the transfer is never abandoned because
        // the launched word must stay stable until the channel lets go.
        if ((state_q == ST_WAIT_ACCEPT || state_q == ST_WAIT_DONE)
                && wd_d == WD_W'(G_TIMEOUT)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= G_ID_W'(G_REQUESTERS - 1);
            wd_q    <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            ready_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign o_gnt         = gnt_q;
    assign o_done        = done_q;
    assign o_cdc_ready   = ready_q;
    assign o_cdc_data    = data_q;
    assign o_err_timeout = err_q;

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
module tb_cdc_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int TO = 8;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic [N-1:0]    i_req = '0;
    logic [N*W-1:0]  i_data = '0;
    logic [N-1:0]    o_gnt;
    logic [N-1:0]    o_done;
    logic            o_cdc_ready;
    logic [W+1:0]    o_cdc_data;
    logic            i_cdc_busy = 1'b1;
    logic            o_err_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int last_win = N - 1;   // reference model: last granted client
    bit err_sticky = 0;     // reference model: watchdog flag

    always #5 i_clk = ~i_clk;

    cdc_tx_arbiter #(.G_REQUESTERS(N), .G_WIDTH(W), .G_TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_data(i_data),
        .o_gnt(o_gnt), .o_done(o_done), .o_cdc_ready(o_cdc_ready),
        .o_cdc_data(o_cdc_data), .i_cdc_busy(i_cdc_busy),
        .o_err_timeout(o_err_timeout)
    );

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] data;
        logic [N-1:0]   exp_gnt;
        logic [W+1:0]   exp_data;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first requester scanning upward from last+1.
    function automatic int rr_winner(input int last, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit exp_err(input int j);
        return err_sticky || ((j - 1) >= TO);
    endfunction

    // One complete transfer. j counts edges since the grant edge; the
    // channel raises busy after edge 1 and holds it for rt samples.
    task automatic do_xfer(input logic [N-1:0] req, input logic [N*W-1:0] data, input int rt,
                           input logic [N-1:0] exp_gnt, input logic [W+1:0] exp_data);
        bit seen;
        int j;
        i_req = req;
        i_data = data;
        i_cdc_busy = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge i_clk); #1;
            if (o_gnt != '0) seen = 1;
        end
        chk("gnt_seen", 32'(seen), 32'd1);
        if (!seen) begin
            i_req = '0;
            return;
        end
        chk("gnt", 32'(o_gnt), 32'(exp_gnt));
        chk("cdc_data", 32'(o_cdc_data), 32'(exp_data));
        chk("ready_hi", 32'(o_cdc_ready), 32'd1);
        chk("err_at_gnt", 32'(o_err_timeout), 32'(err_sticky));
        i_req = '0;
        i_data = N*W'($urandom);   // client changes its data right after grant
        @(posedge i_clk); #1;
        j = 1;
        chk("ready_lo", 32'(o_cdc_ready), 32'd0);
        chk("gnt_pulse", 32'(o_gnt), 32'd0);
        chk("data_hold", 32'(o_cdc_data), 32'(exp_data));
        i_cdc_busy = 1'b1;
        for (j = 2; j <= 1 + rt; j++) begin
            @(posedge i_clk); #1;
            chk("data_hold", 32'(o_cdc_data), 32'(exp_data));
            chk("done_early", 32'(o_done), 32'd0);
            chk("err_wait", 32'(o_err_timeout), 32'(exp_err(j)));
        end
        i_cdc_busy = 1'b0;
        seen = 0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(posedge i_clk); #1;
            if (o_done != '0) seen = 1;
            else j++;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("done", 32'(o_done), 32'(exp_gnt));
        chk("done_vs_gnt", 32'(o_gnt), 32'd0);
        chk("data_at_done", 32'(o_cdc_data), 32'(exp_data));
        chk("err_done", 32'(o_err_timeout), 32'(exp_err(j)));
        if (exp_err(j)) err_sticky = 1;
        @(posedge i_clk); #1;
        chk("done_pulse", 32'(o_done), 32'd0);
    endtask

    initial begin
        logic [N-1:0]   rq;
        logic [N*W-1:0] dt;
        int             w;

        tbl[0]  = '{4'b0001, 16'hDCBA, 4'b0001, 6'h0A};
        tbl[1]  = '{4'b1111, 16'hDCBA, 4'b0010, 6'h1B};
        tbl[2]  = '{4'b1111, 16'hDCBA, 4'b0100, 6'h2C};
        tbl[3]  = '{4'b1111, 16'hDCBA, 4'b1000, 6'h3D};
        tbl[4]  = '{4'b1111, 16'hDCBA, 4'b0001, 6'h0A};
        tbl[5]  = '{4'b1111, 16'hDCBA, 4'b0010, 6'h1B};
        tbl[6]  = '{4'b1010, 16'hDCBA, 4'b1000, 6'h3D};
        tbl[7]  = '{4'b1010, 16'hDCBA, 4'b0010, 6'h1B};
        tbl[8]  = '{4'b0100, 16'hDCBA, 4'b0100, 6'h2C};
        tbl[9]  = '{4'b1001, 16'hDCBA, 4'b1000, 6'h3D};
        tbl[10] = '{4'b0011, 16'hDCBA, 4'b0001, 6'h0A};

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_gnt", 32'(o_gnt), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_ready", 32'(o_cdc_ready), 32'd0);
        chk("rst_data", 32'(o_cdc_data), 32'd0);
        chk("rst_err", 32'(o_err_timeout), 32'd0);
        i_rst_n = 1'b1;

        // Post-reset busy blocks grants
        i_req = 4'b0001;
        i_data = 16'hDCBA;
        for (int c = 0; c < 4; c++) begin
            @(posedge i_clk); #1;
            chk("hold_no_gnt", 32'(o_gnt), 32'd0);
        end

        // Directed table
        for (int t = 0; t < 11; t++) begin
            do_xfer(tbl[t].req, tbl[t].data, 1 + (t % 3), tbl[t].exp_gnt, tbl[t].exp_data);
            last_win = rr_winner(last_win, tbl[t].req);
        end

        // Randomized against the reference model
        for (int t = 0; t < 30; t++) begin
            rq = N'($urandom_range(0, 15));
            dt = N*W'($urandom);
            if (rq == '0) begin
                i_req = '0;
                i_cdc_busy = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(posedge i_clk); #1;
                    chk("idle_no_gnt", 32'(o_gnt), 32'd0);
                end
            end else begin
                w = rr_winner(last_win, rq);
                do_xfer(rq, dt, int'($urandom_range(1, 4)), N'(1 << w),
                        {2'(w), dt[w*W +: W]});
                last_win = w;
            end
        end

        // Watchdog: busy held far beyond the timeout
        dt = 16'h0050;
        do_xfer(4'b0010, dt, 20, 4'b0010, 6'h15);
        last_win = 1;
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk); #1;
            chk("err_sticky", 32'(o_err_timeout), 32'd1);
        end

        // Asynchronous reset while waiting for completion
        i_req = 4'b0100;
        i_data = 16'h0A00;
        i_cdc_busy = 1'b0;
        w = 0;
        for (int c = 0; c < 20 && w == 0; c++) begin
            @(posedge i_clk); #1;
            if (o_gnt != '0) w = 1;
        end
        chk("ar_gnt", 32'(o_gnt), 32'b0100);
        chk("ar_data", 32'(o_cdc_data), 32'h2A);
        i_req = '0;
        @(posedge i_clk); #1;
        i_cdc_busy = 1'b1;
        repeat (3) @(posedge i_clk);
        #3 i_rst_n = 1'b0;
        #1;
        chk("ar_gnt0", 32'(o_gnt), 32'd0);
        chk("ar_done0", 32'(o_done), 32'd0);
        chk("ar_ready0", 32'(o_cdc_ready), 32'd0);
        chk("ar_data0", 32'(o_cdc_data), 32'd0);
        chk("ar_err0", 32'(o_err_timeout), 32'd0);
        err_sticky = 0;
        last_win = N - 1;
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        do_xfer(4'b1111, 16'h4321, 2, 4'b0001, 6'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
